// File: rtl/axis_bram_adapter_pkg.sv
// Shared definitions for the BRAM <-> AXI-Stream adapter controllers:
// sequencer state encoding and default bus widths.
package axis_bram_adapter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 10;
  localparam int LEN_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CMPL = 2'd2
  } state_e;

endpackage

// File: rtl/axis_bram_adapter_rd_ctrl_if.sv
// Word stream from the read controller's buffer head to the M00_AXIS master.
interface axis_bram_adapter_rd_ctrl_if #(
  parameter int DATA_WIDTH = axis_bram_adapter_pkg::DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] DIN_FROM_BUF;
  logic                  DIN_VALID;
  logic                  last;
  logic                  DIN_ACCEP;

  modport master (
    output DIN_FROM_BUF,
    output DIN_VALID,
    output last,
    input  DIN_ACCEP
  );

  modport slave (
    input  DIN_FROM_BUF,
    input  DIN_VALID,
    input  last,
    output DIN_ACCEP
  );

endinterface

// File: rtl/axis_bram_adapter_skid2.sv
// Two-entry synchronous FIFO shared by the adapter's read and write controllers.
// The caller guarantees no write when full and no read when empty.
module axis_bram_adapter_skid2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;

  // NOTE: only two entries, so the storage is reset too; dout then reads zero
  // after reset instead of whatever the entries held before.
  // NOTE: every register here is updated with <= so all reads in this block see
  // the values from before the clock edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (rd_en) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end

  assign dout      = mem_q[rd_ptr_q];
  assign occupancy = count_q;

endmodule

// File: rtl/axis_bram_adapter_rd_ctrl.sv
// Read-side sequencer: walks a BRAM region from BASE_ADDR for XFER_LEN words and
// streams them out through a 2-entry buffer that hides the BRAM read latency.
module axis_bram_adapter_rd_ctrl #(
  parameter int DATA_WIDTH = axis_bram_adapter_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = axis_bram_adapter_pkg::ADDR_WIDTH,
  parameter int LEN_WIDTH  = axis_bram_adapter_pkg::LEN_WIDTH
) (
  input  logic                        M_AXIS_ACLK,
  input  logic                        M_AXIS_ARESETN,
  input  logic                        START,
  input  logic [ADDR_WIDTH-1:0]       BASE_ADDR,
  input  logic [LEN_WIDTH-1:0]        XFER_LEN,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        BRAM_EN,
  output logic [ADDR_WIDTH-1:0]       BRAM_ADDR,
  input  logic [DATA_WIDTH-1:0]       BRAM_DOUT,
  axis_bram_adapter_rd_ctrl_if.master m_axis
);

  import axis_bram_adapter_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [LEN_WIDTH-1:0]  accepted_q, accepted_d;
  logic                  inflight_q;

  logic [1:0]            occupancy;
  logic [DATA_WIDTH-1:0] head;
  logic                  head_valid;
  logic                  head_is_last;
  logic                  beat;
  logic                  final_beat;
  logic [2:0]            pending;
  logic                  issue;

  axis_bram_adapter_skid2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (M_AXIS_ACLK),
    .rst_n     (M_AXIS_ARESETN),
    .wr_en     (inflight_q),
    .din       (BRAM_DOUT),
    .rd_en     (beat),
    .dout      (head),
    .occupancy (occupancy)
  );

  assign head_valid   = (occupancy != 2'd0);
  assign head_is_last = (accepted_q == len_q - LEN_ONE);
  assign beat         = head_valid && m_axis.DIN_ACCEP;
  assign final_beat   = beat && head_is_last;

  // Words the buffer will hold next cycle before any new read; the word leaving
  // this cycle frees its slot so a full-rate stream never bubbles.
  assign pending = {1'b0, occupancy} + {2'b00, inflight_q} - {2'b00, beat};
  assign issue   = (state_q == ST_RUN) && (issued_q < len_q) && (pending < 3'd2);

  // NOTE: every signal driven here gets its default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          addr_d     = BASE_ADDR;
          len_d      = XFER_LEN;
          issued_d   = '0;
          accepted_d = '0;
          state_d    = (XFER_LEN == '0) ? ST_CMPL : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          addr_d   = addr_q + ADDR_ONE;
          issued_d = issued_q + LEN_ONE;
        end
        if (beat) begin
          accepted_d = accepted_q + LEN_ONE;
        end
        if (final_beat) begin
          state_d = ST_CMPL;
        end
      end
      ST_CMPL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      inflight_q <= issue;
    end
  end

  assign BUSY      = (state_q == ST_RUN);
  assign DONE      = (state_q == ST_CMPL);
  assign BRAM_EN   = issue;
  assign BRAM_ADDR = addr_q;

  assign m_axis.DIN_FROM_BUF = head;
  assign m_axis.DIN_VALID    = head_valid;
  assign m_axis.last         = head_valid && head_is_last;

endmodule

// File: tb/tb_axis_bram_adapter_rd_ctrl.sv
// Self-checking bench for axis_bram_adapter_rd_ctrl: table of transfers plus
// hand-written reset / ignored-START sequences, checked against a scoreboard.
module tb_axis_bram_adapter_rd_ctrl;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [9:0]  base;
    logic [15:0] len;
    int          mode;          // 0: accept always, 1: 1,0,0 repeating, 2: random
    int          restart_at;    // cycle after START to pulse a second START (0: none)
    bit          poke_at_done;  // pulse START in the DONE cycle
    int          exp_beats;
    int          exp_reads;
    int          exp_done_cyc;  // cycles from START to DONE, -1: not checked
  } vec_t;

  logic        clk;
  logic        M_AXIS_ARESETN;
  logic        START;
  logic [9:0]  BASE_ADDR;
  logic [15:0] XFER_LEN;
  logic        BUSY;
  logic        DONE;
  logic        BRAM_EN;
  logic [9:0]  BRAM_ADDR;
  logic [31:0] BRAM_DOUT;

  axis_bram_adapter_rd_ctrl_if #(.DATA_WIDTH(32)) m_if ();

  axis_bram_adapter_rd_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (10),
    .LEN_WIDTH  (16)
  ) dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (M_AXIS_ARESETN),
    .START          (START),
    .BASE_ADDR      (BASE_ADDR),
    .XFER_LEN       (XFER_LEN),
    .BUSY           (BUSY),
    .DONE           (DONE),
    .BRAM_EN        (BRAM_EN),
    .BRAM_ADDR      (BRAM_ADDR),
    .BRAM_DOUT      (BRAM_DOUT),
    .m_axis         (m_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM model: mem[i] = 0xA000 + i, one-cycle read latency.
  logic [31:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000 + 32'(i);
    BRAM_DOUT = '0;
  end
  always @(posedge clk) begin
    if (BRAM_EN) BRAM_DOUT <= mem[BRAM_ADDR];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic accept_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 3) == 1;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Scoreboard state shared between the driver and the monitor.
  beat_t      sb_q[$];
  logic [9:0] addr_exp_q[$];
  int         beat_cnt  = 0;
  int         en_cnt    = 0;
  int         done_cnt  = 0;
  int         valid_cnt = 0;
  logic       zero_len_cmd = 1'b0;

  always @(negedge clk) begin : monitor
    logic        hs;
    logic        stall_prev;
    logic        final_prev;
    logic [31:0] stall_data;
    int          occ_m;
    int          infl_m;
    beat_t       e;
    if (!M_AXIS_ARESETN) begin
      occ_m      = 0;
      infl_m     = 0;
      stall_prev = 1'b0;
      final_prev = 1'b0;
    end else begin
      hs = m_if.DIN_VALID && m_if.DIN_ACCEP;
      if (stall_prev)
        check("stall_hold", {m_if.DIN_VALID, m_if.DIN_FROM_BUF}, {1'b1, stall_data});
      if (BRAM_EN) begin
        en_cnt++;
        check("issue_room", (occ_m + infl_m - int'(hs)) < 2, 1);
        check("read_expected", addr_exp_q.size() != 0, 1);
        if (addr_exp_q.size() != 0) check("bram_addr", BRAM_ADDR, addr_exp_q.pop_front());
      end
      if (m_if.DIN_VALID) valid_cnt++;
      if (DONE) begin
        done_cnt++;
        check("done_after_final", final_prev || zero_len_cmd, 1);
      end
      final_prev = 1'b0;
      if (hs) begin
        beat_cnt++;
        check("beat_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("beat_data", m_if.DIN_FROM_BUF, e.data);
          check("beat_last", m_if.last, e.last);
          final_prev = e.last;
        end
      end
      stall_prev = m_if.DIN_VALID && !m_if.DIN_ACCEP;
      stall_data = m_if.DIN_FROM_BUF;
      occ_m      = occ_m + infl_m - int'(hs);
      infl_m     = int'(BRAM_EN);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  BUSY, 0);
    check({tag, "_done"},  DONE, 0);
    check({tag, "_en"},    BRAM_EN, 0);
    check({tag, "_addr"},  BRAM_ADDR, 0);
    check({tag, "_valid"}, m_if.DIN_VALID, 0);
    check({tag, "_last"},  m_if.last, 0);
    check({tag, "_data"},  m_if.DIN_FROM_BUF, 0);
  endtask

  // Issues one command, drives DIN_ACCEP per mode until DONE, and returns in
  // the cycle after DONE so a following command lands there.
  task automatic run_and_check(input vec_t v);
    int         b0, r0, d0, v0, cyc, budget;
    logic       busy_ok;
    logic [9:0] a;
    b0 = beat_cnt; r0 = en_cnt; d0 = done_cnt; v0 = valid_cnt;
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.base + 10'(i);
      sb_q.push_back('{data: 32'hA000 + {22'd0, a}, last: (i == int'(v.len) - 1)});
      addr_exp_q.push_back(a);
    end
    zero_len_cmd    = (v.len == 16'd0);
    BASE_ADDR       = v.base;
    XFER_LEN        = v.len;
    START           = 1'b1;
    m_if.DIN_ACCEP  = 1'b0;
    cycle();
    START     = 1'b0;
    BASE_ADDR = 10'($urandom);
    XFER_LEN  = 16'($urandom);
    budget  = 4 * int'(v.len) + 20;
    cyc     = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      if (DONE) begin
        cyc = c;
        break;
      end
      if (!BUSY) busy_ok = 1'b0;
      if (c == v.restart_at) begin
        START = 1'b1; BASE_ADDR = 10'd0; XFER_LEN = 16'd3;
      end else begin
        START = 1'b0;
      end
      m_if.DIN_ACCEP = accept_for(v.mode, c);
      cycle();
    end
    check("done_seen", cyc > 0, 1);
    check("busy_during", busy_ok, 1);
    check("busy_at_done", BUSY, 0);
    if (v.exp_done_cyc > 0) check("done_latency", cyc, v.exp_done_cyc);
    if (v.poke_at_done) begin
      START = 1'b1; BASE_ADDR = 10'd0; XFER_LEN = 16'd3;
    end
    cycle();
    START = 1'b0;
    check("beats", beat_cnt - b0, v.exp_beats);
    check("reads", en_cnt - r0, v.exp_reads);
    check("done_pulses", done_cnt - d0, 1);
    check("sb_drained", sb_q.size(), 0);
    check("reads_drained", addr_exp_q.size(), 0);
    if (v.len == 16'd0) check("zero_len_valid", valid_cnt - v0, 0);
  endtask

  vec_t vecs[7];
  vec_t hv;

  initial begin
    int   b0, d0, r0;
    logic reached;

    vecs[0] = '{base: 10'h004, len: 16'd8,  mode: 0, restart_at: 0, poke_at_done: 0,
                exp_beats: 8,  exp_reads: 8,  exp_done_cyc: 11};
    vecs[1] = '{base: 10'h014, len: 16'd5,  mode: 1, restart_at: 0, poke_at_done: 0,
                exp_beats: 5,  exp_reads: 5,  exp_done_cyc: -1};
    vecs[2] = '{base: 10'h009, len: 16'd0,  mode: 0, restart_at: 0, poke_at_done: 0,
                exp_beats: 0,  exp_reads: 0,  exp_done_cyc: 1};
    vecs[3] = '{base: 10'h01E, len: 16'd1,  mode: 0, restart_at: 0, poke_at_done: 0,
                exp_beats: 1,  exp_reads: 1,  exp_done_cyc: 4};
    vecs[4] = '{base: 10'h3FE, len: 16'd4,  mode: 0, restart_at: 0, poke_at_done: 0,
                exp_beats: 4,  exp_reads: 4,  exp_done_cyc: 7};
    vecs[5] = '{base: 10'h3F0, len: 16'd40, mode: 2, restart_at: 0, poke_at_done: 0,
                exp_beats: 40, exp_reads: 40, exp_done_cyc: -1};
    vecs[6] = '{base: 10'h064, len: 16'd16, mode: 0, restart_at: 5, poke_at_done: 0,
                exp_beats: 16, exp_reads: 16, exp_done_cyc: 19};

    M_AXIS_ARESETN = 1'b0;
    START          = 1'b0;
    BASE_ADDR      = '0;
    XFER_LEN       = '0;
    m_if.DIN_ACCEP = 1'b0;
    cycle();
    cycle();
    check_reset_outputs("reset");
    M_AXIS_ARESETN = 1'b1;
    cycle();

    for (int i = 0; i < 7; i++) run_and_check(vecs[i]);

    // START pulsed while DONE is high must be dropped.
    hv = '{base: 10'h1F4, len: 16'd2, mode: 0, restart_at: 0, poke_at_done: 1,
           exp_beats: 2, exp_reads: 2, exp_done_cyc: 5};
    run_and_check(hv);
    b0 = beat_cnt; d0 = done_cnt; r0 = en_cnt;
    repeat (8) cycle();
    check("poke_no_beats", beat_cnt - b0, 0);
    check("poke_no_done",  done_cnt - d0, 0);
    check("poke_no_reads", en_cnt - r0, 0);

    // Reset after 3 of 10 beats abandons the transfer silently.
    for (int i = 0; i < 10; i++) begin
      sb_q.push_back('{data: 32'hA000 + 32'(200 + i), last: (i == 9)});
      addr_exp_q.push_back(10'(200 + i));
    end
    zero_len_cmd   = 1'b0;
    b0 = beat_cnt; d0 = done_cnt;
    BASE_ADDR      = 10'd200;
    XFER_LEN       = 16'd10;
    START          = 1'b1;
    cycle();
    START          = 1'b0;
    m_if.DIN_ACCEP = 1'b1;
    reached        = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (beat_cnt - b0 >= 3) begin
        reached = 1'b1;
        break;
      end
      cycle();
    end
    check("rst_reached_3", reached, 1);
    M_AXIS_ARESETN = 1'b0;
    m_if.DIN_ACCEP = 1'b0;
    cycle();
    check_reset_outputs("rst_mid");
    sb_q.delete();
    addr_exp_q.delete();
    M_AXIS_ARESETN = 1'b1;
    m_if.DIN_ACCEP = 1'b1;
    repeat (6) cycle();
    check("rst_beats_frozen", beat_cnt - b0, 3);
    check("rst_no_done", done_cnt - d0, 0);

    hv = '{base: 10'h032, len: 16'd3, mode: 0, restart_at: 0, poke_at_done: 0,
           exp_beats: 3, exp_reads: 3, exp_done_cyc: 6};
    run_and_check(hv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", failures);
    $fatal(1, "watchdog expired");
  end

endmodule
